alu_uart_if: RTL and testbench
==============================

ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; SHALL equal 8 (one UART byte per operand).
REQ-002 Parameter OP_WIDTH, default 6, ALU opcode width.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, idle cycles allowed between bytes of one frame.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  byte from UART receiver; valid only when rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle pulse, new byte on rx_data.
REQ-008 tx_data  output  8  byte to UART transmitter.
REQ-009 tx_start  output  1  one-cycle pulse, transmitter loads tx_data.
REQ-010 tx_done  input  1  one-cycle pulse, transmitter finished current byte.
REQ-011 A  output  DATA_WIDTH  ALU operand A, registered.
REQ-012 B  output  DATA_WIDTH  ALU operand B, registered.
REQ-013 Op  output  OP_WIDTH  ALU opcode, registered.
REQ-014 Result  input  DATA_WIDTH  ALU combinational result.
REQ-015 Overflow  input  1  ALU signed-overflow flag.
REQ-016 Zero  input  1  ALU zero flag.
REQ-017 busy  output  1  high from EXEC through WAIT_STAT.
REQ-018 timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-019 States SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT.
REQ-020 Frame SHALL be three bytes in order A, B, Op; response SHALL be two bytes: Result, then status {6'b0, Overflow, Zero}.
REQ-021 WAIT_A/WAIT_B: rx_valid SHALL load rx_data into A/B and advance to WAIT_B/WAIT_OP next cycle.
REQ-022 WAIT_OP: rx_valid SHALL load rx_data[OP_WIDTH-1:0] into Op (upper bits ignored) and go to EXEC.
REQ-023 EXEC SHALL last exactly one cycle; at its end Result and {Overflow,Zero} are captured into internal registers.
REQ-024 SEND_RES SHALL assert tx_start for exactly one cycle with tx_data=captured Result, then go to WAIT_RES.
REQ-025 WAIT_RES on tx_done SHALL go to SEND_STAT; SEND_STAT pulses tx_start one cycle with tx_data=status byte; WAIT_STAT on tx_done SHALL go to WAIT_A.
REQ-026 Latency: tx_start for Result SHALL occur exactly 2 cycles after the cycle rx_valid delivers the Op byte.
REQ-027 tx_data SHALL hold stable from its tx_start cycle until the matching tx_done.
REQ-028 rx_valid in EXEC..WAIT_STAT SHALL be ignored (byte dropped, no state change); tx_done outside WAIT_RES/WAIT_STAT SHALL be ignored.
REQ-029 Inter-byte counter SHALL clear on every accepted byte and in WAIT_A, and increment each cycle in WAIT_B/WAIT_OP.
REQ-030 Counter reaching TIMEOUT_CYCLES-1 without rx_valid SHALL return to WAIT_A and pulse timeout; rx_valid in that same cycle SHALL win (byte accepted, no timeout).
REQ-031 A, B, Op SHALL hold their values between frames and after timeout until overwritten.

Reset
REQ-032 reset=1 SHALL on the next edge force state WAIT_A and A, B, Op, tx_data, tx_start, busy, timeout, counter, captured registers to 0.
REQ-033 Reset mid-frame or mid-response SHALL abort it; no further tx_start until a new full frame is received.
REQ-034 reset SHALL take priority over rx_valid and tx_done in the same cycle.

Verification (bench: simple_alu connected to A/B/Op/Result/Overflow/Zero, transmitter model returning tx_done 10 cycles after tx_start)
REQ-035 Frame 0x05,0x0A,0x20 (ADD) -> tx bytes 0x0F then 0x00; Result tx_start exactly 2 cycles after Op byte.
REQ-036 Frame 0x7F,0x01,0x20 -> 0x80 then 0x02; frame 0xAA,0x55,0x24 (AND) -> 0x00 then 0x01.
REQ-037 Send 0x05 then idle TIMEOUT_CYCLES cycles -> one timeout pulse, no tx_start; next frame 0x0A,0x05,0x22 (SUB) -> 0x05 then 0x00.
REQ-038 Extra rx_valid 0x33 during WAIT_RES -> ignored; response unchanged; following frame decoded from its own first byte.
REQ-039 reset asserted in WAIT_STAT -> all outputs 0 next cycle, no status tx_start; following frame responds normally.
REQ-040 Op byte 0xC1 (invalid, upper bits set) -> Op=6'b000001, tx bytes 0x00 then 0x01.

Source files
------------

// File: rtl/alu_uart_if.sv
// UART framing front-end for a combinational ALU: collects the bytes A, B, Op,
// runs one EXEC cycle, then returns the Result byte followed by a status byte.
module alu_uart_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [OP_WIDTH-1:0]   Op,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  Overflow,
  input  logic                  Zero,
  output logic                  busy,
  output logic                  timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic [1:0]            flags_q, flags_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    flags_d    = flags_q;
    timeout_d  = 1'b0;
    case (state_q)
      WAIT_A: begin
        cnt_d = '0;
        if (rx_valid) begin
          a_d     = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        // A byte arriving on the last allowed cycle still counts.
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == WAIT_B) begin
            b_d     = rx_data;
            state_d = WAIT_OP;
          end else begin
            op_d    = rx_data[OP_WIDTH-1:0];
            state_d = EXEC;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        // tx_data doubles as the captured Result until the status byte replaces it.
        tx_data_d  = Result;
        flags_d    = {Overflow, Zero};
        tx_start_d = 1'b1;
        state_d    = SEND_RES;
      end
      SEND_RES: state_d = WAIT_RES;
      WAIT_RES: begin
        if (tx_done) begin
          tx_data_d  = {6'b0, flags_q};
          tx_start_d = 1'b1;
          state_d    = SEND_STAT;
        end
      end
      SEND_STAT: state_d = WAIT_STAT;
      WAIT_STAT: begin
        if (tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
    busy_d = (state_d == EXEC) || (state_d == SEND_RES) || (state_d == WAIT_RES) ||
             (state_d == SEND_STAT) || (state_d == WAIT_STAT);
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Op       = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: small ALU and a UART transmitter model (tx_done 10
// cycles after tx_start), directed and random frames against an arithmetic model.
module tb_alu_uart_if;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done = 1'b0;
  logic [7:0] A, B;
  logic [5:0] Op;
  logic [7:0] Result;
  logic       Overflow, Zero;
  logic       busy, timeout;

  int checks = 0;
  int errors = 0;

  alu_uart_if #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .A(A), .B(B), .Op(Op), .Result(Result), .Overflow(Overflow), .Zero(Zero),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // simple_alu: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, anything else yields 0
  always_comb begin
    Result   = 8'h00;
    Overflow = 1'b0;
    case (Op)
      6'h20: begin
        Result   = A + B;
        Overflow = (A[7] == B[7]) && (Result[7] != A[7]);
      end
      6'h22: begin
        Result   = A - B;
        Overflow = (A[7] != B[7]) && (Result[7] != A[7]);
      end
      6'h24: Result = A & B;
      6'h25: Result = A | B;
      default: Result = 8'h00;
    endcase
    Zero = (Result == 8'h00);
  end

  // Transmitter model plus a log of every transmitted byte and its edge index.
  int         cyc = 0;
  int         tcnt = 0;
  int         stab_err = 0;
  int         tout_cnt = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] txq[$];
  int         tsq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (timeout === 1'b1) tout_cnt <= tout_cnt + 1;
    if (reset) begin
      tcnt    <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start === 1'b1) begin
        txq.push_back(tx_data);
        tsq.push_back(cyc);
        cur  <= tx_data;
        tcnt <= 10;
      end else if (tcnt != 0) begin
        if (tx_data !== cur) stab_err <= stab_err + 1;
        tcnt <= tcnt - 1;
        if (tcnt == 1) tx_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, overflow as range escape.
  function automatic void model(input int a, input int b, input int op,
                                output int res, output int stat);
    int sa, sb, s, ov;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    ov = 0;
    case (op % 64)
      32: begin s = sa + sb; ov = (s > 127 || s < -128); res = (s + 512) % 256; end
      34: begin s = sa - sb; ov = (s > 127 || s < -128); res = (s + 512) % 256; end
      36: res = a & b;
      37: res = a | b;
      default: res = 0;
    endcase
    stat = ov * 2 + ((res == 0) ? 1 : 0);
  endfunction

  // Called at a negedge; the byte is sampled on the following rising edge.
  task automatic send_byte(input int b);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input int a, input int b, input int op, input bit inj, input int gap);
    int n0, res, stat, opk;
    bit ok;
    n0 = txq.size();
    model(a, b, op, res, stat);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(b);
    opk = cyc;
    send_byte(op);
    if (inj) begin
      repeat (4) @(negedge clk);
      send_byte(8'h33);
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (txq.size() >= n0 + 2) && (busy === 1'b0);
    end
    chk("frame_done", 32'(ok), 1);
    if (ok) begin
      chk("result_byte", txq[n0], res);
      chk("status_byte", txq[n0+1], stat);
      chk("result_latency", tsq[n0] - opk, 2);
      chk("byte_count", txq.size() - n0, 2);
    end
    chk("A_reg", A, a);
    chk("B_reg", B, b);
    chk("Op_reg", Op, op % 64);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(tag, {A, B, Op, tx_data, tx_start, busy, timeout}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, t0, opi, a, b, op;
    int ops[5] = '{32, 34, 36, 37, 0};
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);

    run_frame(8'h05, 8'h0A, 8'h20, 1'b0, 0);
    run_frame(8'h7F, 8'h01, 8'h20, 1'b0, 0);
    run_frame(8'hAA, 8'h55, 8'h24, 1'b0, 0);

    // Partial frame then silence: one timeout pulse, nothing transmitted.
    t0 = tout_cnt;
    n0 = txq.size();
    send_byte(8'h05);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_pulses", tout_cnt - t0, 1);
    chk("timeout_no_tx", txq.size() - n0, 0);
    chk("A_held_after_timeout", A, 8'h05);
    run_frame(8'h0A, 8'h05, 8'h22, 1'b0, 0);

    // B arrives on the very cycle the counter hits its limit.
    t0 = tout_cnt;
    run_frame(8'h11, 8'h22, 8'h20, 1'b0, TO - 1);
    chk("boundary_no_timeout", tout_cnt - t0, 0);

    // Stray byte while waiting on the transmitter.
    run_frame(8'h30, 8'h0C, 8'h22, 1'b1, 0);
    run_frame(8'h01, 8'h02, 8'h25, 1'b0, 0);

    // Reset while waiting for the Result byte to finish: no status byte.
    n0 = txq.size();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h20);
    for (int i = 0; i < 50 && txq.size() < n0 + 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset_in_wait_res");
    repeat (30) @(negedge clk);
    chk("no_status_after_reset", txq.size() - n0, 1);
    run_frame(8'h03, 8'h04, 8'h20, 1'b0, 0);

    // Reset while waiting for the status byte to finish.
    n0 = txq.size();
    send_byte(8'h40); send_byte(8'h40); send_byte(8'h20);
    for (int i = 0; i < 80 && txq.size() < n0 + 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset_in_wait_stat");
    repeat (30) @(negedge clk);
    chk("no_tx_after_reset", txq.size() - n0, 2);
    run_frame(8'h0A, 8'h05, 8'h22, 1'b0, 0);

    // Upper opcode bits dropped.
    run_frame(8'h05, 8'h0A, 8'hC1, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      a   = $urandom_range(0, 255);
      b   = $urandom_range(0, 255);
      opi = $urandom_range(0, 4);
      op  = (opi == 4) ? $urandom_range(0, 255) : ops[opi];
      run_frame(a, b, op, 1'b0, $urandom_range(0, 5));
    end

    chk("tx_data_stable", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
